thumb_fetch: RTL and testbench
==============================

# thumb_fetch

Instruction fetch front end for the 16-bit Thumb execute core. Reads 32-bit words from instruction memory over a request/acknowledge port, splits each word into two little-endian halfwords, buffers them with their addresses, and presents one 16-bit `cmd` per cycle to the executor under a valid/ready handshake. A branch redirect from the executor flushes the buffer and restarts fetch, including discarding any in-flight memory reply.

## Interface
- `DEPTH`, 4: halfword buffer entries; power of two, ≥ 2.
- `RESET_PC`, 32'h0000_0000: fetch address after reset; bit 0 ignored.

- `sck`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `mem_req`  out  1  read request; held until acknowledged.
- `mem_addr`  out  32  word address, bits [1:0] = 0; stable while `mem_req`=1.
- `mem_ack`  in  1  sampled only when `mem_req`=1; completes the transaction on that edge.
- `mem_rdata`  in  32  read data, valid with `mem_ack`.
- `cmd`  out  16  instruction halfword.
- `cmd_pc`  out  32  halfword address of `cmd`.
- `cmd_valid`  out  1  `cmd`/`cmd_pc` valid.
- `cmd_ready`  in  1  executor accepts; a transfer occurs when `cmd_valid` & `cmd_ready`.
- `redirect`  in  1  branch taken; one-cycle pulse.
- `redirect_pc`  in  32  new PC; bit 0 ignored.

## Operation
- Reset: `mem_req`=0, `mem_addr`={RESET_PC[31:2],2'b00}, `cmd_valid`=0, `cmd`=0, `cmd_pc`=0, buffer empty, `skip_lo`=RESET_PC[1], state F_IDLE.
- States:
  - F_IDLE: issue when free entries ≥ 2 (after this cycle's pop); raise `mem_req` with `mem_addr`=fetch_pc → F_WAIT.
  - F_WAIT: on `mem_ack`, push halfwords: low half (`mem_rdata`[15:0], pc = fetch_pc) unless `skip_lo`, then high half (`mem_rdata`[31:16], pc = fetch_pc+2). Clear `skip_lo`; fetch_pc += 4, wrapping 32'hFFFF_FFFC → 0. The next request may issue back-to-back on the same edge if space allows; otherwise → F_IDLE.
  - F_DROP: hold `mem_req`/`mem_addr`; on `mem_ack` discard data; → F_IDLE, or issue immediately at the new fetch_pc.
- Redirect (priority over everything that cycle):
  - Flush buffer.
  - fetch_pc ← {redirect_pc[31:2],2'b00}; `skip_lo` ← redirect_pc[1].
  - F_WAIT without ack → F_DROP. A request is never withdrawn.
  - F_WAIT with ack in the same cycle: data discarded → F_IDLE.
  - Redirect in F_DROP: update fetch_pc/`skip_lo`, stay in F_DROP.
  - A transfer completing in the redirect cycle counts as accepted.
- Buffer:
  - Push 0/1/2, pop 0/1 in the same cycle; count += push − pop.
  - Never overflows, because issue requires 2 free entries and only one request is outstanding.
  - Empty → `cmd_valid`=0. `cmd`/`cmd_pc` hold their values while `cmd_valid`=1 and `cmd_ready`=0.

## Timing
- `rst` high on edge E: all outputs at reset values after E. First `mem_req`=1 after the first edge with `rst` low.
- `mem_ack` on edge A (empty buffer): `cmd_valid`=1 after A, with the lower-address halfword first.
- `redirect` on edge R: `cmd_valid`=0 after R.
  - From F_IDLE: new `mem_req`/`mem_addr` after R, so the first new `cmd` appears after the ack edge at R+1 or later.
- Throughput: with zero-wait memory (ack on the first edge `mem_req` is high) and the executor always ready, 1 cmd per cycle is sustained at DEPTH ≥ 4.
- `rst` mid-transaction abandons the request; the memory side must tolerate `mem_req` dropping on reset.

## Structure
- Shared package `thumb_pkg`:
  - `HW_W`=16, `WORD_W`=32.
  - Enum `fetch_state_t` {F_IDLE, F_WAIT, F_DROP}.
  - Function `word_align(pc)`.
  - The `PC`/`LR` register indices belong here as well, for sharing with the executor.
- Sub-module `hw_fifo`:
  - Parameterised DEPTH.
  - Entry = {pc[31:1], halfword}.
  - 2-push/1-pop, synchronous flush, exports `count`/`free`.
- Top level: state machine, fetch_pc/`skip_lo` registers, issue logic.

## Test plan
- Reset with RESET_PC=32'h0000_0100, zero-wait memory returning 32'hBBBB_AAAA at 0x100 and 32'hDDDD_CCCC at 0x104, `cmd_ready`=1 → `mem_addr` 0x100 then 0x104; `cmd` sequence AAAA@0x100, BBBB@0x102, CCCC@0x104, DDDD@0x106 on consecutive cycles.
- `cmd_ready`=0 throughout, DEPTH=4 → exactly 2 requests issued, then `mem_req` stays 0; `cmd` holds AAAA@0x100. Raise `cmd_ready` → all four halfwords drain in order, then fetch resumes at 0x108.
- Redirect to 0x0000_0202 from F_IDLE → next `mem_addr`=0x200; first `cmd` is the high half of word 0x200 with `cmd_pc`=0x202.
- Memory with 3-cycle ack latency; redirect to 0x400 one cycle after a request to 0x108 → `mem_addr` stays 0x108 until ack; that data never appears on `cmd`; next `mem_addr`=0x400.
- Redirect on the same edge as `mem_ack` → that data is discarded; next request goes to the redirect address one cycle later.
- RESET_PC=32'hFFFF_FFFC → `mem_addr` 0xFFFF_FFFC then 0x0000_0000; `cmd_pc` values 0xFFFF_FFFC, 0xFFFF_FFFE, 0x0000_0000.

Source files
------------

// File: rtl/thumb_pkg.sv
// Shared definitions for the Thumb fetch front end and execute core.
package thumb_pkg;

    localparam int HW_W   = 16;
    localparam int WORD_W = 32;

    // Register-file indices shared with the executor.
    localparam int REG_LR = 14;
    localparam int REG_PC = 15;

    typedef enum logic [1:0] {
        F_IDLE,
        F_WAIT,
        F_DROP
    } fetch_state_t;

    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] pc);
        return pc & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/hw_fifo.sv
// Halfword buffer: up to two pushes and one pop per cycle, each entry tagged with pc[31:1].
module hw_fifo
    import thumb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned ENTRY_W = WORD_W - 1 + HW_W,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [1:0]         push,
    input  logic [ENTRY_W-1:0] push_data0,
    input  logic [ENTRY_W-1:0] push_data1,
    input  logic               pop,
    output logic [ENTRY_W-1:0] head,
    output logic [CW-1:0]      count,
    output logic [CW-1:0]      free
);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      wr_ptr;
    logic [CW-1:0]      cnt;

    // push_data0 always lands first so the lower-address halfword leaves first.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push != 2'd0) begin
                mem[wr_ptr] <= push_data0;
            end
            if (push == 2'd2) begin
                mem[wr_ptr + AW'(1)] <= push_data1;
            end
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            cnt    <= cnt + CW'(push) - CW'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign count = cnt;
    assign free  = CW'(DEPTH) - cnt;

endmodule

// File: rtl/thumb_fetch.sv
// Thumb instruction fetch: word requests to memory, halfword stream to the executor,
// with branch redirect flushing the buffer and dropping any in-flight reply.
module thumb_fetch
    import thumb_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        sck,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [15:0] cmd,
    output logic [31:0] cmd_pc,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned ENTRY_W = WORD_W - 1 + HW_W;
    localparam int unsigned CW      = $clog2(DEPTH + 1);
    localparam int unsigned NW      = CW + 1;

    fetch_state_t       state;
    logic [31:0]        fetch_pc;
    logic               skip_lo;
    logic [31:0]        redirect_word;
    logic               data_ack;
    logic [1:0]         push;
    logic               pop;
    logic [ENTRY_W-1:0] lo_entry;
    logic [ENTRY_W-1:0] hi_entry;
    logic [ENTRY_W-1:0] push_data0;
    logic [ENTRY_W-1:0] head;
    logic [CW-1:0]      count;
    logic [CW-1:0]      free;
    logic [NW-1:0]      free_next;
    logic               issue_ok;

    assign redirect_word = word_align(redirect_pc);
    assign data_ack      = (state == F_WAIT) && mem_ack && !redirect;
    assign push          = data_ack ? (skip_lo ? 2'd1 : 2'd2) : 2'd0;
    assign pop           = cmd_valid & cmd_ready;
    assign lo_entry      = {fetch_pc[31:2], 1'b0, mem_rdata[15:0]};
    assign hi_entry      = {fetch_pc[31:2], 1'b1, mem_rdata[31:16]};
    assign push_data0    = skip_lo ? hi_entry : lo_entry;

    // Room for a whole word after this cycle's push and pop; one request in flight at most.
    assign free_next = {1'b0, free} + NW'(pop) - NW'(push);
    assign issue_ok  = free_next >= NW'(2);

    assign cmd_valid = (count != '0);
    assign cmd       = head[HW_W-1:0];
    assign cmd_pc    = {head[ENTRY_W-1:HW_W], 1'b0};

    hw_fifo #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk        (sck),
        .rst        (rst),
        .flush      (redirect),
        .push       (push),
        .push_data0 (push_data0),
        .push_data1 (hi_entry),
        .pop        (pop),
        .head       (head),
        .count      (count),
        .free       (free)
    );

    always_ff @(posedge sck) begin
        if (rst) begin
            state    <= F_IDLE;
            mem_req  <= 1'b0;
            mem_addr <= word_align(RESET_PC);
            fetch_pc <= word_align(RESET_PC);
            skip_lo  <= RESET_PC[1];
        end else begin
            unique case (state)
                F_IDLE: begin
                    if (redirect) begin
                        fetch_pc <= redirect_word;
                        skip_lo  <= redirect_pc[1];
                        mem_req  <= 1'b1;
                        mem_addr <= redirect_word;
                        state    <= F_WAIT;
                    end else if (issue_ok) begin
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_pc;
                        state    <= F_WAIT;
                    end
                end
                F_WAIT: begin
                    if (redirect) begin
                        fetch_pc <= redirect_word;
                        skip_lo  <= redirect_pc[1];
                        if (mem_ack) begin
                            mem_req <= 1'b0;
                            state   <= F_IDLE;
                        end else begin
                            state <= F_DROP;
                        end
                    end else if (mem_ack) begin
                        skip_lo  <= 1'b0;
                        fetch_pc <= fetch_pc + 32'd4;
                        if (issue_ok) begin
                            mem_addr <= fetch_pc + 32'd4;
                        end else begin
                            mem_req <= 1'b0;
                            state   <= F_IDLE;
                        end
                    end
                end
                F_DROP: begin
                    // Request stays up until acked; its data is never used.
                    if (redirect) begin
                        fetch_pc <= redirect_word;
                        skip_lo  <= redirect_pc[1];
                        if (mem_ack) begin
                            mem_req <= 1'b0;
                            state   <= F_IDLE;
                        end
                    end else if (mem_ack) begin
                        if (issue_ok) begin
                            mem_addr <= fetch_pc;
                            state    <= F_WAIT;
                        end else begin
                            mem_req <= 1'b0;
                            state   <= F_IDLE;
                        end
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    state   <= F_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_thumb_fetch.sv
// Directed and randomised checks of thumb_fetch against a halfword-stream reference model.
module tb_thumb_fetch;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic        sck = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_ack, cmd_valid, cmd_ready, redirect;
    logic [31:0] mem_addr, mem_rdata, cmd_pc, redirect_pc;
    logic [15:0] cmd;

    thumb_fetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .sck         (sck),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .cmd         (cmd),
        .cmd_pc      (cmd_pc),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 sck = ~sck;

    int n_vec = 0;
    int n_bad = 0;
    int cycle = 0;
    int n_issue = 0;
    int n_xfer = 0;
    int lat = 0;
    int wcnt = 0;
    int lat_mode = 0;
    bit in_req = 1'b0;
    bit tainted = 1'b0;
    bit ack_redirect = 1'b0;
    bit found;
    logic [31:0] ack_redirect_pc;
    // Model: halfwords [exp_pc, buf_end) have been delivered by memory and not yet consumed.
    logic [31:0] exp_pc, buf_end, req_addr;
    logic [31:0] r;
    logic [31:0] iq[$];
    logic [31:0] xq[$];
    int          cq[$];

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hBBBB_AAAA;
        if (a == 32'h0000_0104) return 32'hDDDD_CCCC;
        return {a[17:2] ^ 16'hC3A5, a[17:2]};
    endfunction

    function automatic logic [15:0] hw_at(input logic [31:0] pc);
        logic [31:0] w;
        w = word_at({pc[31:2], 2'b00});
        return pc[1] ? w[31:16] : w[15:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        bit ack, xfer, was_rst, was_redir;
        logic [31:0] rnd;
        was_rst = rst;
        ack = 1'b0;
        xfer = 1'b0;
        if (!rst) begin
            check("cmd_valid", 32'(cmd_valid), 32'(buf_end != exp_pc));
            if (buf_end != exp_pc) begin
                check("cmd_pc", cmd_pc, exp_pc);
                check("cmd", 32'(cmd), 32'(hw_at(exp_pc)));
                xfer = cmd_ready;
            end
            if (in_req) begin
                check("mem_req_held", 32'(mem_req), 32'd1);
                check("mem_addr_stable", mem_addr, req_addr);
            end else if (mem_req) begin
                req_addr = {buf_end[31:2], 2'b00};
                check("mem_addr_issue", mem_addr, req_addr);
                iq.push_back(mem_addr);
                n_issue++;
                in_req = 1'b1;
                tainted = 1'b0;
                wcnt = 0;
                lat = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
            end
            ack = in_req && (wcnt >= lat);
            if (ack && ack_redirect) begin
                redirect = 1'b1;
                redirect_pc = ack_redirect_pc;
                ack_redirect = 1'b0;
            end
        end
        was_redir = redirect && !rst;
        rnd = $urandom();
        mem_ack = ack;
        mem_rdata = ack ? word_at(mem_addr) : rnd;
        if (xfer) begin
            xq.push_back(cmd_pc);
            cq.push_back(cycle);
            n_xfer++;
        end
        @(posedge sck);
        #1;
        cycle++;
        redirect = 1'b0;
        mem_ack = 1'b0;
        if (was_rst) begin
            exp_pc = {RESET_PC[31:1], 1'b0};
            buf_end = exp_pc;
            in_req = 1'b0;
            tainted = 1'b0;
            n_issue = 0;
            iq.delete();
            xq.delete();
            cq.delete();
        end else begin
            if (xfer) exp_pc = exp_pc + 32'd2;
            if (ack) begin
                if (!tainted && !was_redir) buf_end = req_addr + 32'd4;
                in_req = 1'b0;
            end else if (in_req) begin
                wcnt++;
            end
            if (was_redir) begin
                if (in_req) tainted = 1'b1;
                exp_pc = {redirect_pc[31:1], 1'b0};
                buf_end = exp_pc;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, {RESET_PC[31:2], 2'b00});
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_cmd", 32'(cmd), 32'd0);
        check("rst_cmd_pc", cmd_pc, 32'd0);
        rst = 1'b0;
    endtask

    task automatic wait_req(input logic [31:0] addr, input int budget, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            step();
            hit = mem_req && (mem_addr == addr);
        end
    endtask

    initial begin
        int n0;
        cmd_ready = 1'b1;
        redirect = 1'b0;
        redirect_pc = '0;
        mem_ack = 1'b0;
        mem_rdata = '0;

        // Zero-wait memory, always-ready executor.
        lat_mode = 0;
        do_reset();
        step();
        check("first_req", 32'(mem_req), 32'd1);
        check("first_addr", mem_addr, 32'h0000_0100);
        repeat (10) step();
        check("t1_issue0", iq[0], 32'h0000_0100);
        check("t1_issue1", iq[1], 32'h0000_0104);
        for (int i = 0; i < 4; i++) begin
            check("t1_pc", xq[i], 32'h0000_0100 + 32'(2 * i));
            check("t1_consecutive", 32'(cq[i]), 32'(cq[0] + i));
        end
        n0 = xq.size();
        repeat (20) step();
        check("t1_rate", 32'(xq.size() - n0), 32'd20);

        // Stalled executor: exactly two words fetched, head held.
        cmd_ready = 1'b0;
        do_reset();
        repeat (12) step();
        check("t2_issues", 32'(n_issue), 32'd2);
        check("t2_req_idle", 32'(mem_req), 32'd0);
        check("t2_hold_cmd", 32'(cmd), 32'h0000_AAAA);
        check("t2_hold_pc", cmd_pc, 32'h0000_0100);
        cmd_ready = 1'b1;
        repeat (8) step();
        for (int i = 0; i < 4; i++) begin
            check("t2_drain", xq[i], 32'h0000_0100 + 32'(2 * i));
        end
        check("t2_resume", iq[2], 32'h0000_0108);

        // Redirect from idle to an odd halfword.
        cmd_ready = 1'b0;
        do_reset();
        repeat (6) step();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0202;
        step();
        xq.delete();
        check("t3_req", 32'(mem_req), 32'd1);
        check("t3_addr", mem_addr, 32'h0000_0200);
        check("t3_valid", 32'(cmd_valid), 32'd0);
        cmd_ready = 1'b1;
        repeat (4) step();
        check("t3_first_pc", xq[0], 32'h0000_0202);

        // Redirect while a slow request is in flight.
        lat_mode = 3;
        do_reset();
        wait_req(32'h0000_0108, 60, found);
        check("t4_reach_108", 32'(found), 32'd1);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0400;
        step();
        xq.delete();
        check("t4_hold_addr", mem_addr, 32'h0000_0108);
        check("t4_hold_req", 32'(mem_req), 32'd1);
        check("t4_valid", 32'(cmd_valid), 32'd0);
        wait_req(32'h0000_0400, 20, found);
        check("t4_reach_400", 32'(found), 32'd1);
        repeat (10) step();
        check("t4_first_pc", xq[0], 32'h0000_0400);

        // Redirect on the same edge as an ack.
        lat_mode = 2;
        do_reset();
        repeat (6) step();
        ack_redirect = 1'b1;
        ack_redirect_pc = 32'h0000_0600;
        for (int i = 0; i < 20 && ack_redirect; i++) step();
        check("t5_fired", 32'(ack_redirect), 32'd0);
        check("t5_req_dropped", 32'(mem_req), 32'd0);
        check("t5_valid", 32'(cmd_valid), 32'd0);
        xq.delete();
        step();
        check("t5_req", 32'(mem_req), 32'd1);
        check("t5_addr", mem_addr, 32'h0000_0600);
        repeat (8) step();
        check("t5_first_pc", xq[0], 32'h0000_0600);

        // Address wrap at the top of memory.
        cmd_ready = 1'b0;
        lat_mode = 0;
        do_reset();
        repeat (6) step();
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        iq.delete();
        xq.delete();
        cmd_ready = 1'b1;
        repeat (6) step();
        check("t6_issue0", iq[0], 32'hFFFF_FFFC);
        check("t6_issue1", iq[1], 32'h0000_0000);
        check("t6_pc0", xq[0], 32'hFFFF_FFFC);
        check("t6_pc1", xq[1], 32'hFFFF_FFFE);
        check("t6_pc2", xq[2], 32'h0000_0000);

        // Random latency, back-pressure, redirects and occasional reset.
        lat_mode = -1;
        cmd_ready = 1'b1;
        do_reset();
        n0 = n_xfer;
        for (int i = 0; i < 1500; i++) begin
            r = $urandom();
            cmd_ready = (r[1:0] != 2'b00);
            if (r[9:4] == 6'd0) begin
                redirect = 1'b1;
                redirect_pc = {20'h0, r[27:16]};
            end
            if (r[31:22] == 10'd0) do_reset();
            else step();
        end
        check("rand_progress", 32'(n_xfer - n0 > 200), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
